// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared constants and types for the differential BPSK modulator.
// Contents: symbol period lengths, rate_sel encoding, DAC mid-scale, PN9 seed/taps,
//           and the quarter-wave sine table used by sine_lut_256.
package bpsk_pkg;
  localparam int SYM_N_10K = 3200;
  localparam int SYM_N_8K = 4000;
  localparam int SYM_N_6K = 5333;
  typedef enum logic [1:0] {
    RATE_10K = 2'd0,
    RATE_8K = 2'd1,
    RATE_6K = 2'd2,
    RATE_10K_B = 2'd3
  } rate_e;
  localparam logic [9:0] DA_MID = 10'd512;
  localparam logic [8:0] PN_SEED = 9'h1FF;
  // x^9 + x^5 + 1: feedback from lfsr[8] and lfsr[4]
  localparam logic [8:0] PN_TAPS = 9'h110;
  // round(511 * sin(2*pi*k/256)) for k = 0..64; the other three quadrants follow by symmetry
  localparam logic [8:0] QSIN [0:64] = '{
    9'd0, 9'd13, 9'd25, 9'd38, 9'd50, 9'd63, 9'd75, 9'd87,
    9'd100, 9'd112, 9'd124, 9'd136, 9'd148, 9'd160, 9'd172, 9'd184,
    9'd196, 9'd207, 9'd218, 9'd230, 9'd241, 9'd252, 9'd263, 9'd273,
    9'd284, 9'd294, 9'd304, 9'd314, 9'd324, 9'd334, 9'd343, 9'd352,
    9'd361, 9'd370, 9'd379, 9'd387, 9'd395, 9'd403, 9'd410, 9'd418,
    9'd425, 9'd432, 9'd438, 9'd445, 9'd451, 9'd456, 9'd462, 9'd467,
    9'd472, 9'd477, 9'd481, 9'd485, 9'd489, 9'd492, 9'd496, 9'd499,
    9'd501, 9'd503, 9'd505, 9'd507, 9'd509, 9'd510, 9'd510, 9'd511,
    9'd511
  };
  function automatic logic [12:0] sym_last(rate_e r);
    return r == RATE_8K ? 13'(SYM_N_8K - 1) : r == RATE_6K ? 13'(SYM_N_6K - 1) : 13'(SYM_N_10K - 1);
  endfunction
endpackage

// File: rtl/bpsk_mod_if.sv
// bpsk_mod_if: control/data bundle between a bit source and the BPSK modulator.
// Signals: en, rate_sel, data_in (source -> modulator);
//          data_req, code_out, da_data (modulator -> source/DAC).
// Modports: master = bit source / controller, slave = modulator.
interface bpsk_mod_if;
  logic en;
  logic [1:0] rate_sel;
  logic data_in;
  logic data_req;
  logic code_out;
  logic [9:0] da_data;
  modport master(output en, rate_sel, data_in, input data_req, code_out, da_data);
  modport slave(input en, rate_sel, data_in, output data_req, code_out, da_data);
endinterface

// File: rtl/sine_lut_256.sv
// sine_lut_256: registered 256-entry sine lookup, entry k = round(511*sin(2*pi*k/256)).
// Ports:
//   clk_32m - clock
//   rst_n   - asynchronous active-low reset (output clears to 0)
//   addr_i  - 8-bit phase address
//   data_o  - 10-bit two's-complement sample, one cycle after addr_i
module sine_lut_256
  import bpsk_pkg::*;
(
  input  logic       clk_32m,
  input  logic       rst_n,
  input  logic [7:0] addr_i,
  output logic [9:0] data_o
);
  logic [6:0] k_w;
  logic [8:0] mag_w;
  logic [9:0] data_d, data_q;
  // second and fourth quadrants read the quarter table backwards
  assign k_w = addr_i[6] ? 7'd64 - {1'b0, addr_i[5:0]} : {1'b0, addr_i[5:0]};
  assign mag_w = QSIN[k_w];
  assign data_d = addr_i[7] ? -{1'b0, mag_w} : {1'b0, mag_w};
  assign data_o = data_q;
  always_ff @(posedge clk_32m or negedge rst_n)
    if (!rst_n) data_q <= '0;
    else data_q <= data_d;
endmodule

// File: rtl/bpsk_mod.sv
// bpsk_mod: differential BPSK modulator, DDS carrier through a 256-entry sine LUT,
//           10-bit offset-binary output for the AD path.
// Build option: define BPSK_MOD_PN_EN to replace data_in with an internal PN9 source
//               (x^9+x^5+1, seed 9'h1FF, reseeded while en=0).
// Ports:
//   clk_32m - sole clock (32 MHz)
//   rst_n   - asynchronous active-low reset
//   bus     - bpsk_mod_if.slave: en, rate_sel, data_in in; data_req, code_out, da_data out
// Latency: phase/code change reaches da_data two cycles later.
module bpsk_mod
  import bpsk_pkg::*;
#(
  parameter logic [31:0] CARRIER_FCW = 32'h1000_0000
) (
  input logic clk_32m,
  input logic rst_n,
  bpsk_mod_if.slave bus
);
  logic [31:0] phase_q, phase_d;
  logic [12:0] sym_cnt_q, sym_cnt_d;
  rate_e rate_q, rate_d;
  logic code_q, code_d;
  logic [9:0] da_q, da_d;
  logic [9:0] lut_w;
  logic [7:0] addr_w;
  logic last_w, bit_w;
  assign last_w = sym_cnt_q == sym_last(rate_q);
  assign bus.data_req = bus.en && last_w;
  assign bus.code_out = code_q;
  assign bus.da_data = da_q;
`ifdef BPSK_MOD_PN_EN
  logic [8:0] lfsr_q, lfsr_d;
  assign bit_w = lfsr_q[8];
  assign lfsr_d = !bus.en ? PN_SEED : bus.data_req ? {lfsr_q[7:0], ^(lfsr_q & PN_TAPS)} : lfsr_q;
  always_ff @(posedge clk_32m or negedge rst_n)
    if (!rst_n) lfsr_q <= PN_SEED;
    else lfsr_q <= lfsr_d;
`else
  assign bit_w = bus.data_in;
`endif
  // the code bit adds half a turn (128 of 256 LUT steps)
  assign addr_w = phase_q[31:24] + {code_q, 7'b0};
  sine_lut_256 u_lut (
    .clk_32m(clk_32m),
    .rst_n  (rst_n),
    .addr_i (addr_w),
    .data_o (lut_w)
  );
  always_comb begin
    phase_d = bus.en ? phase_q + CARRIER_FCW : '0;
    sym_cnt_d = (!bus.en || last_w) ? '0 : sym_cnt_q + 13'd1;
    // rate is only taken at a symbol boundary, or freely while idle
    rate_d = (!bus.en || last_w) ? rate_e'(bus.rate_sel) : rate_q;
    code_d = bus.en ? code_q ^ (last_w & bit_w) : 1'b0;
    da_d = bus.en ? {~lut_w[9], lut_w[8:0]} : DA_MID;
  end
  always_ff @(posedge clk_32m or negedge rst_n)
    if (!rst_n) begin
      phase_q <= '0;
      sym_cnt_q <= '0;
      rate_q <= RATE_10K;
      code_q <= 1'b0;
      da_q <= DA_MID;
    end else begin
      phase_q <= phase_d;
      sym_cnt_q <= sym_cnt_d;
      rate_q <= rate_d;
      code_q <= code_d;
      da_q <= da_d;
    end
endmodule

// File: tb/tb_bpsk_mod.sv
// tb_bpsk_mod: scoreboard bench for bpsk_mod against a sample-level reference model.
module tb_bpsk_mod;
  localparam logic [31:0] FCW = 32'h1000_0000;
  localparam int HIST = 131072;
  typedef struct packed {
    logic [9:0] da;
    logic req;
    logic code;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bpsk_mod_if bus ();
  bpsk_mod #(.CARRIER_FCW(FCW)) dut (
    .clk_32m(clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  exp_t exp_q[$];
  int req_q[$];
  int da_hist[HIST];
  int t, pos, rate_l, samp_p, d_m;
  logic code_m;
`ifdef BPSK_MOD_PN_EN
  bit pn_seq[511];
  int pn_k;
  initial begin
    for (int k = 0; k < 511; k++) pn_seq[k] = k < 9 ? 1'b1 : pn_seq[k-9] ^ pn_seq[k-5];
  end
`endif
  always @(posedge clk) cyc_n <= cyc_n + 1;
  function automatic int sym_n(int r);
    return r == 1 ? 4000 : r == 2 ? 5333 : 3200;
  endfunction
  function automatic int sinv(int k);
    real r;
    r = 511.0 * $sin(2.0 * 3.141592653589793 * k / 256.0);
    return r < 0.0 ? -$rtoi(0.5 - r) : $rtoi(r + 0.5);
  endfunction
  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  // reference model: one expected output triple per clock cycle
  always @(negedge clk) begin
    exp_t e;
    logic rq, b;
    logic [31:0] ph;
    if (!rst_n) begin
      t = 0; pos = 0; rate_l = 0; samp_p = 512; d_m = 512; code_m = 1'b0;
`ifdef BPSK_MOD_PN_EN
      pn_k = 0;
`endif
      e = '{da: 10'd512, req: 1'b0, code: 1'b0};
      exp_q.push_back(e);
    end else begin
      rq = bus.en && pos == sym_n(rate_l) - 1;
      e = '{da: 10'(d_m), req: rq, code: code_m};
      exp_q.push_back(e);
`ifdef BPSK_MOD_PN_EN
      b = pn_seq[pn_k % 511];
`else
      b = bus.data_in;
`endif
      ph = FCW * 32'(t);
      d_m = bus.en ? samp_p : 512;
      samp_p = 512 + sinv((int'(ph[31:24]) + (code_m ? 128 : 0)) % 256);
      if (!bus.en) begin
        t = 0; pos = 0; code_m = 1'b0;
`ifdef BPSK_MOD_PN_EN
        pn_k = 0;
`endif
      end else begin
        t++;
        pos = rq ? 0 : pos + 1;
        if (rq) begin
          code_m = code_m ^ b;
`ifdef BPSK_MOD_PN_EN
          pn_k++;
`endif
        end
      end
      if (!bus.en || rq) rate_l = int'(bus.rate_sel);
    end
  end
  // monitor: pops one expectation per presented sample
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({bus.da_data, bus.data_req, bus.code_out} !== {e.da, e.req, e.code}) begin
        bad++;
        $display("FAIL sb cyc=%0d: got da=%0d req=%0b code=%0b, expected da=%0d req=%0b code=%0b",
                 cyc_n, bus.da_data, bus.data_req, bus.code_out, e.da, e.req, e.code);
      end
    end
    if (cyc_n < HIST) da_hist[cyc_n] = int'(bus.da_data);
    if (bus.data_req === 1'b1) req_q.push_back(cyc_n);
  end
  initial begin
    int c0, r1, r3;
    bus.en = 1'b0; bus.rate_sel = 2'd0; bus.data_in = 1'b0;
    run(5);
    rst_n = 1'b1;
    run(100);
    req_q.delete();
    bus.en = 1'b1;
    c0 = cyc_n;
    run(4200);
    bus.rate_sel = 2'd1;
    run(3200);
    bus.rate_sel = 2'd2;
    run(9433);
    chk("req_count", req_q.size(), 4);
    if (req_q.size() == 4) begin
      chk("first_req", req_q[0] - c0, 3199);
      chk("space_10k", req_q[1] - req_q[0], 3200);
      chk("space_8k", req_q[2] - req_q[1], 4000);
      chk("space_6k", req_q[3] - req_q[2], 5333);
    end
    bus.en = 1'b0; bus.rate_sel = 2'd0;
    run(10);
`ifndef BPSK_MOD_PN_EN
    req_q.delete();
    bus.data_in = 1'b0;
    bus.en = 1'b1;
    run(6500);
    bus.data_in = 1'b1;
    run(3300);
    chk("flip_reqs", req_q.size(), 3);
    if (req_q.size() == 3) begin
      r1 = req_q[0];
      r3 = req_q[2];
      for (int j = 0; j < 16; j++) begin
        chk("no_flip", da_hist[r1+3+j], da_hist[r1+3+j-160]);
        chk("flip", da_hist[r3+3+j], 1024 - da_hist[r3+3+j-160]);
      end
    end
    chk("code_after_one", int'(bus.code_out), 1);
    bus.en = 1'b0;
    run(10);
`endif
    bus.data_in = 1'b1;
    bus.en = 1'b1;
    run(4200);
    chk("code_before_drop", int'(bus.code_out), 1);
    bus.en = 1'b0;
    run(1);
    chk("drop_da", int'(bus.da_data), 512);
    chk("drop_code", int'(bus.code_out), 0);
    run(10);
    req_q.delete();
    bus.en = 1'b1;
    run(3199);
    bus.en = 1'b0;
    run(2);
    chk("req_drop_none", req_q.size(), 0);
    chk("req_drop_code", int'(bus.code_out), 0);
    for (int k = 0; k < 12; k++) begin
      int n;
      bus.en = k == 5 || $urandom_range(0, 3) != 0;
      bus.rate_sel = 2'($urandom);
      n = $urandom_range(300, 4000);
      for (int i = 0; i < n; i++) begin
        bus.data_in = 1'($urandom);
        if ($urandom_range(0, 499) == 0) bus.rate_sel = 2'($urandom);
        if (k == 5 && i == n / 2) rst_n = 1'b0;
        if (k == 5 && i == n / 2 + 3) rst_n = 1'b1;
        run(1);
      end
    end
    run(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
